rob_retire: RTL

//  In-order reorder/retire buffer at the back end of the OoO core. Accepts groups of

---
 rtl/rob_retire.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rob_retire.sv
// In-order reorder/retire buffer: allocates uop groups, collects completions and retires in order,
// returning superseded aliases to the free list. Define ROB_STATS_EN to add retire/stall counters.
module rob_retire #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned RETIRE_WIDTH = 4,
  parameter int unsigned CMPLT_PORTS  = 2,
  parameter int unsigned ROB_DEPTH    = 32,
  parameter int unsigned PR_ADDR_W    = 6,
  localparam int unsigned ROB_ADDR_W  = $clog2(ROB_DEPTH),
  localparam int unsigned RN_W        = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*PR_ADDR_W*FETCH_WIDTH-1:0]    i_alloc_aliases,
  input  logic [FETCH_WIDTH-1:0]                i_alloc_mask,
  input  logic                                  i_alloc_valid,
  output logic                                  o_alloc_ready,
  output logic [ROB_ADDR_W*FETCH_WIDTH-1:0]     o_rob_idx,
  input  logic [CMPLT_PORTS-1:0]                i_cmplt_valid,
  input  logic [ROB_ADDR_W*CMPLT_PORTS-1:0]     i_cmplt_idx,
  output logic [2*PR_ADDR_W*RETIRE_WIDTH-1:0]   o_free_regs,
  output logic [2*RETIRE_WIDTH-1:0]             o_free_mask,
  output logic [RN_W-1:0]                       o_retire_num
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                           o_retire_cnt,
  output logic [31:0]                           o_full_stall_cnt
`endif
);

  localparam int unsigned PTR_W = ROB_ADDR_W + 1;
  localparam int unsigned AL_W  = 2 * PR_ADDR_W;

  logic [PTR_W-1:0]                r_head;
  logic [PTR_W-1:0]                r_tail;
  logic [PTR_W-1:0]                r_count;
  logic [ROB_DEPTH-1:0]            r_valid;
  logic [ROB_DEPTH-1:0]            r_done;
  logic [AL_W-1:0]                 r_alias [ROB_DEPTH];
  logic [2*PR_ADDR_W*RETIRE_WIDTH-1:0] r_free_regs;
  logic [2*RETIRE_WIDTH-1:0]       r_free_mask;
  logic [RN_W-1:0]                 r_retire_num;

  logic                            w_ready;
  logic                            w_fire;
  logic [ROB_ADDR_W-1:0]           w_alloc_idx [FETCH_WIDTH];
  logic [ROB_ADDR_W-1:0]           w_ret_idx [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0]         w_ret_en;
  logic [RN_W-1:0]                 w_ret_k;

  // Credit comes only from the registered count; same-cycle retirement does not help.
  assign w_ready = (PTR_W'(ROB_DEPTH) - r_count) >= PTR_W'(FETCH_WIDTH);
  assign w_fire  = i_alloc_valid & w_ready;

  assign o_alloc_ready = w_ready;
  assign o_free_regs   = r_free_regs;
  assign o_free_mask   = r_free_mask;
  assign o_retire_num  = r_retire_num;

  always_comb begin
    for (int g = 0; g < FETCH_WIDTH; g++) begin
      w_alloc_idx[g] = r_tail[ROB_ADDR_W-1:0] + ROB_ADDR_W'(g);
      o_rob_idx[ROB_ADDR_W*g +: ROB_ADDR_W] = w_alloc_idx[g];
    end
  end

  // Leading run of valid&done entries from head, capped at RETIRE_WIDTH.
  always_comb begin
    logic run;
    run     = 1'b1;
    w_ret_k = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      w_ret_idx[j] = r_head[ROB_ADDR_W-1:0] + ROB_ADDR_W'(j);
      run          = run & r_valid[w_ret_idx[j]] & r_done[w_ret_idx[j]];
      w_ret_en[j]  = run;
      w_ret_k      = w_ret_k + RN_W'(run);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_valid      <= '0;
      r_done       <= '0;
      r_free_regs  <= '0;
      r_free_mask  <= '0;
      r_retire_num <= '0;
    end else begin
      for (int p = 0; p < CMPLT_PORTS; p++) begin
        if (i_cmplt_valid[p] && r_valid[i_cmplt_idx[ROB_ADDR_W*p +: ROB_ADDR_W]]) begin
          r_done[i_cmplt_idx[ROB_ADDR_W*p +: ROB_ADDR_W]] <= 1'b1;
        end
      end
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (w_ret_en[j]) begin
          r_valid[w_ret_idx[j]] <= 1'b0;
          r_done[w_ret_idx[j]]  <= 1'b0;
        end
      end
      if (w_fire) begin
        for (int g = 0; g < FETCH_WIDTH; g++) begin
          r_valid[w_alloc_idx[g]] <= 1'b1;
          r_done[w_alloc_idx[g]]  <= ~i_alloc_mask[g];
        end
        r_tail <= r_tail + PTR_W'(FETCH_WIDTH);
      end
      r_head  <= r_head + PTR_W'(w_ret_k);
      r_count <= r_count + (w_fire ? PTR_W'(FETCH_WIDTH) : '0) - PTR_W'(w_ret_k);
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        r_free_regs[AL_W*j +: AL_W] <= w_ret_en[j] ? r_alias[w_ret_idx[j]] : '0;
        r_free_mask[2*j]   <= w_ret_en[j] & (|r_alias[w_ret_idx[j]][PR_ADDR_W-1:0]);
        r_free_mask[2*j+1] <= w_ret_en[j] & (|r_alias[w_ret_idx[j]][AL_W-1:PR_ADDR_W]);
      end
      r_retire_num <= w_ret_k;
    end
  end

  // Alias payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && w_fire) begin
      for (int g = 0; g < FETCH_WIDTH; g++) begin
        r_alias[w_alloc_idx[g]] <= i_alloc_mask[g] ? i_alloc_aliases[AL_W*g +: AL_W] : '0;
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [ROB_DEPTH-1:0] r_real;
  logic [RN_W-1:0]      w_ret_real;
  logic [31:0]          r_retire_cnt;
  logic [31:0]          r_full_stall_cnt;

  assign o_retire_cnt     = r_retire_cnt;
  assign o_full_stall_cnt = r_full_stall_cnt;

  always_comb begin
    w_ret_real = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      w_ret_real = w_ret_real + RN_W'(w_ret_en[j] & r_real[w_ret_idx[j]]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fire) begin
      for (int g = 0; g < FETCH_WIDTH; g++) begin
        r_real[w_alloc_idx[g]] <= i_alloc_mask[g];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt     <= '0;
      r_full_stall_cnt <= '0;
    end else begin
      r_retire_cnt <= r_retire_cnt + 32'(w_ret_real);
      if (i_alloc_valid && !w_ready) begin
        r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
